// File: rtl/asrv32_clint_if.sv
// Data-bus request/response bundle between the core LSU (master) and the CLINT (slave).
interface asrv32_clint_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [31:0] i_wb_addr;
  logic [31:0] i_wb_data;
  logic [3:0]  i_wb_sel;
  logic        o_wb_ack;
  logic        o_wb_stall;
  logic [31:0] o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_ack, o_wb_stall, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_ack, o_wb_stall, o_wb_data
  );
endinterface

// File: rtl/asrv32_clint.sv
// Core-local interruptor: MSIP / MTIMECMP / MTIME window on the data bus, feeding the CSR timer unit.
// Optional ASRV32_CLINT_SNAPSHOT_EN: MTIME_LO read latches the high word so MTIME_HI reads back coherently.
module asrv32_clint #(
  parameter logic [31:0] BASE_ADDR    = 32'h0200_0000,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  asrv32_clint_if.slave       wb,
  input  logic [63:0]         i_mtime,
  output logic                o_mtime_wr_en,
  output logic [63:0]         o_mtime_dout,
  output logic                o_mtimecmp_wr_en,
  output logic [63:0]         o_mtimecmp_dout,
  output logic                o_software_interrupt
);

  localparam logic [2:0] OFF_MSIP   = 3'd0;
  localparam logic [2:0] OFF_CMP_LO = 3'd2;
  localparam logic [2:0] OFF_CMP_HI = 3'd3;
  localparam logic [2:0] OFF_MT_LO  = 3'd4;
  localparam logic [2:0] OFF_MT_HI  = 3'd5;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ACK} state_e;

  state_e      state_q, state_d;
  logic        ack_q, ack_d;
  logic        stall_q, stall_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mtime_wr_en_q, mtime_wr_en_d;
  logic [63:0] mtime_dout_q, mtime_dout_d;
  logic        cmp_wr_en_q, cmp_wr_en_d;
  logic [63:0] cmp_dout_q, cmp_dout_d;
  logic        msip_q, msip_d;
  logic [31:0] mtime_lo_q, mtime_lo_d;
  logic [31:0] cmp_lo_q, cmp_lo_d;
`ifdef ASRV32_CLINT_SNAPSHOT_EN
  logic [31:0] snap_q, snap_d;
  logic        snap_vld_q, snap_vld_d;
`endif

  logic       in_window;
  logic       accept;
  logic       sel_full;
  logic [2:0] off;
  logic       unused_addr;

  assign in_window   = (wb.i_wb_addr[31:5] == BASE_ADDR[31:5]);
  assign accept      = wb.i_wb_cyc & wb.i_wb_stb & ~stall_q & in_window & (state_q == ST_IDLE);
  assign sel_full    = (wb.i_wb_sel == 4'hF);
  assign off         = wb.i_wb_addr[4:2];
  assign unused_addr = ^wb.i_wb_addr[1:0];

  // All register side effects happen on the accepting edge so they are visible in the ACK cycle.
  always_comb begin
    state_d       = state_q;
    ack_d         = 1'b0;
    stall_d       = stall_q;
    rdata_d       = 32'd0;
    mtime_wr_en_d = 1'b0;
    mtime_dout_d  = mtime_dout_q;
    cmp_wr_en_d   = 1'b0;
    cmp_dout_d    = cmp_dout_q;
    msip_d        = msip_q;
    mtime_lo_d    = mtime_lo_q;
    cmp_lo_d      = cmp_lo_q;
`ifdef ASRV32_CLINT_SNAPSHOT_EN
    snap_d        = snap_q;
    snap_vld_d    = snap_vld_q;
`endif
    case (state_q)
      ST_INIT: begin
        state_d = ST_IDLE;
        stall_d = 1'b0;
      end
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ACK;
          stall_d = 1'b1;
          ack_d   = 1'b1;
          if (wb.i_wb_we) begin
            case (off)
              OFF_MSIP:   if (wb.i_wb_sel[0]) msip_d = wb.i_wb_data[0];
              OFF_CMP_LO: if (sel_full) cmp_lo_d = wb.i_wb_data;
              OFF_CMP_HI: if (sel_full) begin
                cmp_dout_d  = {wb.i_wb_data, cmp_lo_q};
                cmp_wr_en_d = 1'b1;
              end
              OFF_MT_LO:  if (sel_full) mtime_lo_d = wb.i_wb_data;
              OFF_MT_HI: begin
                if (sel_full) begin
                  mtime_dout_d  = {wb.i_wb_data, mtime_lo_q};
                  mtime_wr_en_d = 1'b1;
                end
`ifdef ASRV32_CLINT_SNAPSHOT_EN
                snap_vld_d = 1'b0;
`endif
              end
              default: ;
            endcase
          end else begin
            case (off)
              OFF_MSIP:   rdata_d = {31'd0, msip_q};
              OFF_CMP_LO: rdata_d = cmp_dout_q[31:0];
              OFF_CMP_HI: rdata_d = cmp_dout_q[63:32];
              OFF_MT_LO: begin
                rdata_d = i_mtime[31:0];
`ifdef ASRV32_CLINT_SNAPSHOT_EN
                snap_d     = i_mtime[63:32];
                snap_vld_d = 1'b1;
`endif
              end
`ifdef ASRV32_CLINT_SNAPSHOT_EN
              OFF_MT_HI:  rdata_d = snap_vld_q ? snap_q : i_mtime[63:32];
`else
              OFF_MT_HI:  rdata_d = i_mtime[63:32];
`endif
              default:    rdata_d = 32'd0;
            endcase
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        stall_d = 1'b0;
      end
      default: begin
        state_d = ST_INIT;
        stall_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_INIT;
      ack_q         <= 1'b0;
      stall_q       <= 1'b1;
      rdata_q       <= 32'd0;
      mtime_wr_en_q <= 1'b0;
      mtime_dout_q  <= 64'd0;
      cmp_wr_en_q   <= 1'b0;
      cmp_dout_q    <= MTIMECMP_RST;
      msip_q        <= 1'b0;
      mtime_lo_q    <= 32'd0;
      cmp_lo_q      <= 32'd0;
`ifdef ASRV32_CLINT_SNAPSHOT_EN
      snap_q        <= 32'd0;
      snap_vld_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      stall_q       <= stall_d;
      rdata_q       <= rdata_d;
      mtime_wr_en_q <= mtime_wr_en_d;
      mtime_dout_q  <= mtime_dout_d;
      cmp_wr_en_q   <= cmp_wr_en_d;
      cmp_dout_q    <= cmp_dout_d;
      msip_q        <= msip_d;
      mtime_lo_q    <= mtime_lo_d;
      cmp_lo_q      <= cmp_lo_d;
`ifdef ASRV32_CLINT_SNAPSHOT_EN
      snap_q        <= snap_d;
      snap_vld_q    <= snap_vld_d;
`endif
    end
  end

  assign wb.o_wb_ack    = ack_q;
  assign wb.o_wb_stall  = stall_q;
  assign wb.o_wb_data   = rdata_q;
  assign o_mtime_wr_en  = mtime_wr_en_q;
  assign o_mtime_dout   = mtime_dout_q;
  // The INIT push must not show while reset is still held, hence the gate on i_rst_n.
  assign o_mtimecmp_wr_en     = cmp_wr_en_q | ((state_q == ST_INIT) & i_rst_n);
  assign o_mtimecmp_dout      = cmp_dout_q;
  assign o_software_interrupt = msip_q;

endmodule

// File: tb/tb_asrv32_clint.sv
// Scoreboard bench for asrv32_clint: directed bus accesses, ack/data checked by a separate monitor.
module tb_asrv32_clint;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk;
  logic        rst_n;
  logic [63:0] mtime;
  logic        mtime_wr_en;
  logic [63:0] mtime_dout;
  logic        cmp_wr_en;
  logic [63:0] cmp_dout;
  logic        sw_irq;

  asrv32_clint_if wb();

  asrv32_clint dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .wb                   (wb),
    .i_mtime              (mtime),
    .o_mtime_wr_en        (mtime_wr_en),
    .o_mtime_dout         (mtime_dout),
    .o_mtimecmp_wr_en     (cmp_wr_en),
    .o_mtimecmp_dout      (cmp_dout),
    .o_software_interrupt (sw_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        chkd;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one expectation; stall must be high in an ACK cycle.
  always @(negedge clk) begin
    if (wb.o_wb_ack === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack (data %h)", wb.o_wb_data);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_stall"}, {63'd0, wb.o_wb_stall}, 64'd1);
        if (mon_e.chkd) chk(mon_e.name, {32'd0, wb.o_wb_data}, {32'd0, mon_e.exp});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  // Drives one request while the DUT is idle; returns 1 time unit into the ACK cycle with cyc/stb dropped.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] sel, input logic chkd, input logic [31:0] exp,
                       input string name, input logic push);
    exp_t e;
    e.chkd = chkd;
    e.exp  = exp;
    e.name = name;
    if (push) sb.push_back(e);
    wb.i_wb_cyc  = 1'b1;
    wb.i_wb_stb  = 1'b1;
    wb.i_wb_we   = we;
    wb.i_wb_addr = addr;
    wb.i_wb_data = wd;
    wb.i_wb_sel  = sel;
    @(posedge clk); #1;
    wb.i_wb_cyc  = 1'b0;
    wb.i_wb_stb  = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] sel, input string name);
    issue(1'b1, addr, wd, sel, 1'b0, 32'd0, name, 1'b1);
    next_cycle();
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    issue(1'b0, addr, 32'd0, 4'hF, 1'b1, exp, name, 1'b1);
    next_cycle();
  endtask

  initial begin
    rst_n        = 1'b0;
    mtime        = 64'd0;
    wb.i_wb_cyc  = 1'b0;
    wb.i_wb_stb  = 1'b0;
    wb.i_wb_we   = 1'b0;
    wb.i_wb_addr = 32'd0;
    wb.i_wb_data = 32'd0;
    wb.i_wb_sel  = 4'h0;

    // Reset held
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cmp_wr_en", {63'd0, cmp_wr_en}, 64'd0);
    chk("rst_ack", {63'd0, wb.o_wb_ack}, 64'd0);
    chk("rst_data", {32'd0, wb.o_wb_data}, 64'd0);
    chk("rst_mtime_wr_en", {63'd0, mtime_wr_en}, 64'd0);
    chk("rst_mtime_dout", mtime_dout, 64'd0);
    chk("rst_cmp_dout", cmp_dout, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_irq", {63'd0, sw_irq}, 64'd0);

    // Release: one INIT cycle
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("init_cmp_wr_en", {63'd0, cmp_wr_en}, 64'd1);
    chk("init_cmp_dout", cmp_dout, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("init_stall", {63'd0, wb.o_wb_stall}, 64'd1);
    next_cycle();
    chk("idle_cmp_wr_en", {63'd0, cmp_wr_en}, 64'd0);
    chk("idle_stall", {63'd0, wb.o_wb_stall}, 64'd0);

    // MTIMECMP assembled from LO then HI
    issue(1'b1, BASE + 32'h08, 32'h1234_5678, 4'hF, 1'b0, 32'd0, "cmp_lo_wr", 1'b1);
    chk("cmp_lo_no_strobe", {63'd0, cmp_wr_en}, 64'd0);
    next_cycle();
    issue(1'b1, BASE + 32'h0C, 32'h0000_00AB, 4'hF, 1'b0, 32'd0, "cmp_hi_wr", 1'b1);
    chk("cmp_hi_strobe", {63'd0, cmp_wr_en}, 64'd1);
    chk("cmp_hi_dout", cmp_dout, 64'h0000_00AB_1234_5678);
    next_cycle();
    chk("cmp_strobe_one_cycle", {63'd0, cmp_wr_en}, 64'd0);
    rd(BASE + 32'h08, 32'h1234_5678, "cmp_lo_rd");
    rd(BASE + 32'h0C, 32'h0000_00AB, "cmp_hi_rd");

    // MSIP with byte enables
    issue(1'b1, BASE, 32'h1, 4'hF, 1'b0, 32'd0, "msip_set", 1'b1);
    chk("msip_set_irq", {63'd0, sw_irq}, 64'd1);
    next_cycle();
    wr(BASE, 32'h0, 4'b0010, "msip_sel_hi0");
    chk("msip_sel_kept1", {63'd0, sw_irq}, 64'd1);
    rd(BASE, 32'h1, "msip_rd1");
    wr(BASE, 32'h0, 4'hF, "msip_clr");
    chk("msip_clr_irq", {63'd0, sw_irq}, 64'd0);
    wr(BASE, 32'h1, 4'b0010, "msip_sel_hi1");
    chk("msip_sel_kept0", {63'd0, sw_irq}, 64'd0);

    // MTIME reads across a carry
    mtime = 64'h1_FFFF_FFFF;
    rd(BASE + 32'h10, 32'hFFFF_FFFF, "mtime_lo_rd");
    mtime = 64'h2_0000_0000;
`ifdef ASRV32_CLINT_SNAPSHOT_EN
    rd(BASE + 32'h14, 32'h1, "mtime_hi_rd_snap");
`else
    rd(BASE + 32'h14, 32'h2, "mtime_hi_rd_live");
`endif

    // MTIME writes
    wr(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, "mtime_lo_wr");
    chk("mtime_lo_no_strobe", {63'd0, mtime_wr_en}, 64'd0);
    issue(1'b1, BASE + 32'h14, 32'h5, 4'hF, 1'b0, 32'd0, "mtime_hi_wr", 1'b1);
    chk("mtime_hi_strobe", {63'd0, mtime_wr_en}, 64'd1);
    chk("mtime_hi_dout", mtime_dout, 64'h0000_0005_DEAD_BEEF);
    next_cycle();
    issue(1'b1, BASE + 32'h14, 32'h9, 4'h3, 1'b0, 32'd0, "mtime_hi_partial", 1'b1);
    chk("mtime_partial_no_strobe", {63'd0, mtime_wr_en}, 64'd0);
    chk("mtime_partial_dout", mtime_dout, 64'h0000_0005_DEAD_BEEF);
    next_cycle();
    issue(1'b1, BASE + 32'h14, 32'h7, 4'hF, 1'b0, 32'd0, "mtime_hi_reuse", 1'b1);
    chk("mtime_reuse_dout", mtime_dout, 64'h0000_0007_DEAD_BEEF);
    next_cycle();

    // Back-to-back reads of an unmapped in-window offset with stb held
    repeat (3) sb.push_back('{1'b1, 32'd0, "b2b_rd_18"});
    wb.i_wb_cyc  = 1'b1;
    wb.i_wb_stb  = 1'b1;
    wb.i_wb_we   = 1'b0;
    wb.i_wb_addr = BASE + 32'h18;
    wb.i_wb_sel  = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin
        wb.i_wb_cyc = 1'b0;
        wb.i_wb_stb = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("b2b_ack_c%0d", k), {63'd0, wb.o_wb_ack}, {63'd0, (k % 2) == 1});
      chk($sformatf("b2b_stall_c%0d", k), {63'd0, wb.o_wb_stall}, {63'd0, (k % 2) == 1});
    end

    // Out-of-window request is ignored
    issue(1'b0, 32'h0300_0010, 32'd0, 4'hF, 1'b0, 32'd0, "oow", 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("oow_no_ack", {63'd0, wb.o_wb_ack}, 64'd0);
    end
    next_cycle();

    // Reset during the ACK of an MTIME_HI write
    wr(BASE + 32'h10, 32'h1111_1111, 4'hF, "pre_rst_lo");
    issue(1'b1, BASE + 32'h14, 32'h2222_2222, 4'hF, 1'b0, 32'd0, "rst_hi", 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_mtime_wr_en", {63'd0, mtime_wr_en}, 64'd0);
    chk("midrst_ack", {63'd0, wb.o_wb_ack}, 64'd0);
    chk("midrst_cmp_wr_en", {63'd0, cmp_wr_en}, 64'd0);
    chk("midrst_mtime_dout", mtime_dout, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("reinit_cmp_wr_en", {63'd0, cmp_wr_en}, 64'd1);
    chk("reinit_cmp_dout", cmp_dout, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("reinit_stall", {63'd0, wb.o_wb_stall}, 64'd1);
    next_cycle();
    chk("reidle_cmp_wr_en", {63'd0, cmp_wr_en}, 64'd0);
    chk("reidle_stall", {63'd0, wb.o_wb_stall}, 64'd0);
    rd(BASE + 32'h0C, 32'hFFFF_FFFF, "cmp_hi_after_rst");

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
